// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, flush and memory-hold sequencing controller
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int BR_FLUSH    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_write,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_hold,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int  FW          = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;
  localparam int  WW          = $clog2(MEM_TIMEOUT + 1);
  localparam bit  MULTI_FLUSH = (BR_FLUSH > 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic mem_stall;
  logic run_rules;

  assign lu = ex_valid & ex_memread & id_valid & (ex_rd != '0) &
              ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
  assign mem_stall = mem_req & ~mem_ack;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    wcnt_d      = wcnt_q;
    timeout_d   = timeout_q;
    run_rules   = 1'b0;
    pc_write    = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          pipe_hold  = 1'b1;
          ifid_stall = 1'b1;
          pc_write   = 1'b0;
          wcnt_d     = WW'(1);
          state_d    = S_MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      S_FLUSH: begin
        // ID holds wrong-path content here, so load-use is never evaluated
        if (mem_stall) begin
          pipe_hold  = 1'b1;
          ifid_stall = 1'b1;
          pc_write   = 1'b0;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          fcnt_d      = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) state_d = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ack) begin
          pipe_hold  = 1'b1;
          ifid_stall = 1'b1;
          pc_write   = 1'b0;
          if (wcnt_q == WW'(MEM_TIMEOUT)) begin
            timeout_d = 1'b1;
            wcnt_d    = '0;
            state_d   = S_RUN;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end else begin
          wcnt_d    = '0;
          state_d   = S_RUN;
          run_rules = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (run_rules) begin
      if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        pc_write    = 1'b1;
        if (MULTI_FLUSH) begin
          fcnt_d  = FW'(BR_FLUSH - 1);
          state_d = S_FLUSH;
        end
      end else if (lu) begin
        ifid_stall  = 1'b1;
        pc_write    = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    stall_cnt_d = (!pc_write && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    // Reset drives a NOP into the pipe and keeps the PC still
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a rule model
module tb_pipe_hazard_ctrl;
  localparam int REG_AW      = 3;
  localparam int BR_FLUSH    = 2;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, ex_valid, ex_memread, br_taken, mem_req, mem_ack;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .BR_FLUSH(BR_FLUSH), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(pc_write), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining flush cycles, cycles spent waiting on memory, sticky timeout, stall count
  int m_flush_left, m_wait, m_stalls;
  bit m_waiting, m_to;
  int n_flush_left, n_wait;
  bit n_waiting, n_to;
  bit e_pc, e_stall, e_flush, e_bub, e_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input bit pc, input bit st, input bit fl, input bit bu, input bit ho);
    chk({tag, "_pc_write"}, 32'(pc_write), 32'(pc));
    chk({tag, "_ifid_stall"}, 32'(ifid_stall), 32'(st));
    chk({tag, "_ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({tag, "_idex_bubble"}, 32'(idex_bubble), 32'(bu));
    chk({tag, "_pipe_hold"}, 32'(pipe_hold), 32'(ho));
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_used = 0; id_rt = '0; id_rt_used = 0;
    ex_valid = 0; ex_memread = 0; ex_rd = '0; br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  function automatic void set_out(bit pc, bit st, bit fl, bit bu, bit ho);
    e_pc = pc; e_stall = st; e_flush = fl; e_bub = bu; e_hold = ho;
  endfunction

  function automatic void apply_run_rules(bit lu);
    if (br_taken) begin
      set_out(1, 0, 1, 1, 0);
      n_flush_left = BR_FLUSH - 1;
    end else if (lu) begin
      set_out(0, 1, 0, 1, 0);
    end
  endfunction

  function automatic void model_eval();
    bit lu;
    lu = ex_valid && ex_memread && id_valid && (ex_rd != 0) &&
         ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    set_out(1, 0, 0, 0, 0);
    n_flush_left = m_flush_left; n_wait = m_wait; n_waiting = m_waiting; n_to = m_to;
    if (m_waiting) begin
      if (!mem_ack) begin
        set_out(0, 1, 0, 0, 1);
        if (m_wait == MEM_TIMEOUT) begin
          n_to = 1; n_waiting = 0; n_wait = 0;
        end else begin
          n_wait = m_wait + 1;
        end
      end else begin
        n_waiting = 0; n_wait = 0;
        apply_run_rules(lu);
      end
    end else if (m_flush_left > 0) begin
      if (mem_req && !mem_ack) set_out(0, 1, 0, 0, 1);
      else begin
        set_out(1, 0, 1, 1, 0);
        n_flush_left = m_flush_left - 1;
      end
    end else if (mem_req && !mem_ack) begin
      set_out(0, 1, 0, 0, 1);
      n_waiting = 1; n_wait = 1;
    end else begin
      apply_run_rules(lu);
    end
  endfunction

  task automatic cyc();
    #1;
    model_eval();
    chk_ctl("model", e_pc, e_stall, e_flush, e_bub, e_hold);
    chk("model_mem_timeout", 32'(mem_timeout), 32'(m_to));
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    @(posedge clk);
    if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
    m_flush_left = n_flush_left; m_wait = n_wait; m_waiting = n_waiting; m_to = n_to;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    idle();
    #1;
    chk_ctl("in_reset", 0, 0, 1, 1, 0);
    chk("in_reset_stall_cnt", 32'(stall_cnt), 0);
    chk("in_reset_mem_timeout", 32'(mem_timeout), 0);
    m_flush_left = 0; m_wait = 0; m_waiting = 0; m_to = 0; m_stalls = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int base;
    int holds;
    bit seen;
    rst = 0;
    idle();
    @(negedge clk);
    do_reset();
    #1 chk_ctl("after_reset", 1, 0, 0, 0, 0);
    cyc();

    // Reset asserted while five cycles into a memory wait
    mem_req = 1;
    repeat (5) cyc();
    do_reset();
    #1 chk_ctl("release", 1, 0, 0, 0, 0);
    chk("release_stall_cnt", 32'(stall_cnt), 0);
    cyc();

    // Load-use on rs, then the bubble reaches EX
    ex_valid = 1; ex_memread = 1; ex_rd = 3; id_valid = 1; id_rs = 3; id_rs_used = 1;
    #1 chk_ctl("lu_rs", 0, 1, 0, 1, 0);
    cyc();
    ex_valid = 0;
    #1 chk_ctl("lu_after", 1, 0, 0, 0, 0);
    cyc();
    ex_valid = 1; ex_rd = 0; id_rs = 0;
    #1 chk_ctl("lu_r0", 1, 0, 0, 0, 0);
    cyc();
    ex_rd = 5; id_rs = 1; id_rt = 5; id_rt_used = 1;
    #1 chk_ctl("lu_rt", 0, 1, 0, 1, 0);
    cyc();
    idle();

    // Taken branch squashes two wrong-path fetches
    br_taken = 1;
    #1 chk_ctl("br_0", 1, 0, 1, 1, 0);
    cyc();
    br_taken = 0;
    ex_valid = 1; ex_memread = 1; ex_rd = 2; id_valid = 1; id_rs = 2; id_rs_used = 1;
    #1 chk_ctl("br_1", 1, 0, 1, 1, 0);
    cyc();
    idle();
    #1 chk_ctl("br_done", 1, 0, 0, 0, 0);
    cyc();

    // Memory ack on the fifth cycle of the request
    base = m_stalls;
    mem_req = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("memw_hold", 32'(pipe_hold), 1);
      cyc();
    end
    mem_ack = 1;
    #1 chk_ctl("memw_ack", 1, 0, 0, 0, 0);
    cyc();
    idle();
    #1 chk("memw_stall_cnt", 32'(stall_cnt), 32'(base + 4));
    cyc();

    // Memory never acks: abandoned after the timeout
    mem_req = 1;
    holds = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (mem_timeout === 1'b1) begin
        seen = 1;
        break;
      end
      if (pipe_hold === 1'b1) holds++;
      cyc();
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_hold_cycles", 32'(holds), 32'(MEM_TIMEOUT + 1));
    mem_req = 0;
    #1 chk_ctl("to_released", 1, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("to_sticky", 32'(mem_timeout), 1);

    // Ack arriving together with a taken branch
    mem_req = 1;
    cyc();
    mem_ack = 1; br_taken = 1;
    #1 chk_ctl("ackbr_0", 1, 0, 1, 1, 0);
    cyc();
    idle();
    #1 chk_ctl("ackbr_1", 1, 0, 1, 1, 0);
    cyc();
    #1 chk_ctl("ackbr_done", 1, 0, 0, 0, 0);
    cyc();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = REG_AW'($urandom_range(0, 3));
      id_rs_used = $urandom_range(0, 1);
      id_rt      = REG_AW'($urandom_range(0, 3));
      id_rt_used = $urandom_range(0, 1);
      ex_valid   = $urandom_range(0, 1);
      ex_memread = $urandom_range(0, 1);
      ex_rd      = REG_AW'($urandom_range(0, 3));
      br_taken   = ($urandom_range(0, 9) == 0);
      if (m_waiting) begin
        mem_req = 1;
        mem_ack = ($urandom_range(0, 3) == 0);
      end else begin
        mem_req = ($urandom_range(0, 4) == 0);
        mem_ack = $urandom_range(0, 1);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
